spi_packet_scheduler: RTL
=========================

Name: spi_packet_scheduler

Overview:
- Sits between the blurred-pixel stream (post-CDC, clk_100mhz domain) and the 6-lane SPI sender.
- Downsamples 2:1 in each axis and assembles LINES-pixel packets.
- Queues the packets, marks frame starts with a sync packet, and triggers the SPI sender one packet at a time, only when the sender reports idle.
- Replaces the free-running shift register and event counter used ahead of the sender today; packet boundaries and frame alignment become deterministic.

Parameters:
- LINES, 6, SPI lanes; pixels per packet.
- DATA_WIDTH, 16, bits per pixel.
- QUEUE_DEPTH, 4, packet queue entries (power of 2).
- SYNC_WORD, 16'hA5A5, value placed on every lane of a sync packet.
- START_TIMEOUT, 8, cycles to wait for spi_busy_in to rise after a trigger.

Ports:
- clk_in  input  1  system clock (clk_100mhz).
- rst_in  input  1  reset.
- pixel_valid_in  input  1  pixel qualifier.
- pixel_data_in  input  DATA_WIDTH  pixel.
- hcount_in  input  11  pixel column.
- vcount_in  input  10  pixel row.
- spi_busy_in  input  1  SPI sender transaction in progress.
- data_out  output  LINES*DATA_WIDTH  packet to sender; lane k = bits [k*DATA_WIDTH +: DATA_WIDTH].
- trigger_out  output  1  one-cycle start pulse to sender.
- drop_count_out  output  16  saturating count of packets dropped on full queue.
- timeout_count_out  output  8  saturating count of start timeouts.

Behaviour:
- Clocking and reset: single clock clk_in. Reset is synchronous and active-high on rst_in.
- Reset values: data_out=0, trigger_out=0, both counters=0, queue empty, lane index=0, FSM=IDLE.
- Reset mid-transaction: the sender is not aborted; the FSM returns to IDLE and does not trigger again until spi_busy_in is sampled low.
- Accept rule: pixel accepted when pixel_valid_in & ~hcount_in[0] & ~vcount_in[0].
- Packet assembly:
  - Accepted pixel is written to lane[idx]; idx increments.
  - When idx==LINES-1, the completed packet is pushed next cycle and idx wraps to 0.
  - Lane 0 holds the earliest pixel.
- Frame start: an accepted pixel with hcount_in==0 and vcount_in==0.
  - Discards any partial packet (idx forced to 0 before this pixel is stored).
  - Pushes a sync entry (see Optional Feature).
  - If a data push and a sync push coincide, the data packet is pushed first and the sync one cycle later. A 1-entry sync pending flag guarantees this.
- Queue entries: {is_sync, packet}. Sync entries store no pixels; data_out is driven to SYNC_WORD on all lanes when a sync entry dispatches.
- Full queue: a push while full and with no pop in the same cycle is dropped, and drop_count_out increments (saturates at 16'hFFFF). A push in the same cycle as a pop always succeeds.
- FSM states: IDLE, LOAD, TRIG, WAIT_START, WAIT_DONE.
  - IDLE: if queue non-empty & ~spi_busy_in -> LOAD. Head is popped and registered into data_out.
  - LOAD -> TRIG: data_out is stable from here until the next LOAD.
  - TRIG: trigger_out=1 for exactly this cycle -> WAIT_START.
  - WAIT_START: spi_busy_in=1 -> WAIT_DONE. After START_TIMEOUT cycles without busy -> IDLE, and timeout_count_out increments (saturating). The packet is not retried.
  - WAIT_DONE: spi_busy_in=0 -> IDLE.
- Latency: sixth pixel accepted in cycle N, queue empty, sender idle -> entry visible N+1, LOAD N+2, trigger_out high in cycle N+3.
- trigger_out is never high on two consecutive cycles and is never asserted while spi_busy_in=1.

Optional Feature:
- Macro: SPI_SYNC_PACKET_EN.
- Defined: a frame start pushes a sync entry (subject to the full rule; a dropped sync counts in drop_count_out).
- Undefined: a frame start only resets the lane index; no sync entries exist and the is_sync bit is removed.

Test Plan:
- Single packet: 12 consecutive valid pixels on row 0, hcount 2..13, data=hcount, busy held low -> one trigger; lanes 0..5 = 2,4,6,8,10,12; trigger_out high exactly 3 cycles after the pixel with hcount=12.
- Odd filtering: pixels on vcount=1 or with odd hcount -> no trigger, idx unchanged.
- Backpressure: busy held high for 2000 cycles while 36 accepted pixels arrive (6 packets) -> 4 queued, drop_count_out=2, then 4 triggers in order once busy toggles 1→0 per transaction.
- Frame start mid-packet (macro defined): 3 pixels, then the frame-start pixel at (0,0) -> sync packet dispatched with all lanes 16'hA5A5, followed by a data packet whose lane 0 = the (0,0) pixel.
- Timeout: busy never rises after a trigger -> return to IDLE after 8 cycles, timeout_count_out=1, next queued packet triggered.
- Reset during WAIT_DONE with busy high -> outputs zeroed; no trigger until busy is sampled low.

Source files
------------

// File: rtl/spi_packet_scheduler_if.sv
// Pixel-in / SPI-sender-out bundle for spi_packet_scheduler.
// master = pixel source plus SPI sender environment, slave = the scheduler.
interface spi_packet_scheduler_if #(
    parameter int LINES      = 6,
    parameter int DATA_WIDTH = 16
);
    logic                        pixel_valid_in;
    logic [DATA_WIDTH-1:0]       pixel_data_in;
    logic [10:0]                 hcount_in;
    logic [9:0]                  vcount_in;
    logic                        spi_busy_in;
    logic [LINES*DATA_WIDTH-1:0] data_out;
    logic                        trigger_out;
    logic [15:0]                 drop_count_out;
    logic [7:0]                  timeout_count_out;

    modport master (
        output pixel_valid_in, pixel_data_in, hcount_in, vcount_in, spi_busy_in,
        input  data_out, trigger_out, drop_count_out, timeout_count_out
    );

    modport slave (
        input  pixel_valid_in, pixel_data_in, hcount_in, vcount_in, spi_busy_in,
        output data_out, trigger_out, drop_count_out, timeout_count_out
    );
endinterface

// File: rtl/spi_packet_scheduler.sv
// Downsamples the pixel stream 2:1, packs LINES pixels per packet, queues them and hands them to the SPI sender.
// Optional macro SPI_SYNC_PACKET_EN: a frame start also queues a sync packet (SYNC_WORD on every lane).
module spi_packet_scheduler #(
    parameter int LINES         = 6,
    parameter int DATA_WIDTH    = 16,
    parameter int QUEUE_DEPTH   = 4,
`ifdef SPI_SYNC_PACKET_EN
    parameter logic [DATA_WIDTH-1:0] SYNC_WORD = 16'hA5A5,
`endif
    parameter int START_TIMEOUT = 8
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    spi_packet_scheduler_if.slave  bus
);
    localparam int IDX_W = $clog2(LINES);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(START_TIMEOUT);
    localparam int PKT_W = LINES * DATA_WIDTH;
`ifdef SPI_SYNC_PACKET_EN
    localparam int ENTRY_W = PKT_W + 1;
`else
    localparam int ENTRY_W = PKT_W;
`endif

    typedef enum logic [2:0] {IDLE, LOAD, TRIG, WAIT_START, WAIT_DONE} state_e;

    state_e                  state_q, state_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   lanes_q [LINES-1];
    logic [DATA_WIDTH-1:0]   lanes_d [LINES-1];
    logic [ENTRY_W-1:0]      mem_q [QUEUE_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [PKT_W-1:0]        data_q, data_d;
    logic                    trigger_q, trigger_d;
    logic [15:0]             drop_q, drop_d;
    logic [7:0]              timeout_q, timeout_d;

    logic                    accept_s, frame_start_s, data_push_s, push_s;
    logic                    pop_s, wr_en_s, drop_s, timeout_inc_s;
    logic                    empty_s, full_s;
    logic [PKT_W-1:0]        pkt_s;
    logic [ENTRY_W-1:0]      push_entry_s, head_s;

    assign accept_s      = bus.pixel_valid_in & ~bus.hcount_in[0] & ~bus.vcount_in[0];
    assign frame_start_s = accept_s && (bus.hcount_in == 11'd0) && (bus.vcount_in == 10'd0);

    // Packet assembly; the last lane is taken straight from the completing pixel
    always_comb begin
        lanes_d     = lanes_q;
        idx_d       = idx_q;
        data_push_s = 1'b0;
        pkt_s       = '0;
        for (int k = 0; k < LINES - 1; k++) begin
            pkt_s[k*DATA_WIDTH +: DATA_WIDTH] = lanes_q[k];
        end
        pkt_s[(LINES-1)*DATA_WIDTH +: DATA_WIDTH] = bus.pixel_data_in;
        if (frame_start_s) begin
            lanes_d[0] = bus.pixel_data_in;
            idx_d      = IDX_W'(1);
        end else if (accept_s) begin
            if (idx_q == IDX_W'(LINES - 1)) begin
                idx_d       = '0;
                data_push_s = 1'b1;
            end else begin
                lanes_d[idx_q] = bus.pixel_data_in;
                idx_d          = idx_q + IDX_W'(1);
            end
        end else begin
            idx_d = idx_q;
        end
    end

`ifdef SPI_SYNC_PACKET_EN
    logic sync_pend_q, sync_pend_d, sync_push_s;

    // A pending sync yields to a data push so the older data packet queues first
    always_comb begin
        sync_push_s  = sync_pend_q && !data_push_s;
        sync_pend_d  = (sync_pend_q && data_push_s) || frame_start_s;
        push_s       = data_push_s || sync_push_s;
        if (data_push_s) begin
            push_entry_s = {1'b0, pkt_s};
        end else begin
            push_entry_s = {1'b1, {PKT_W{1'b0}}};
        end
    end
`else
    assign push_s       = data_push_s;
    assign push_entry_s = pkt_s;
`endif

    assign head_s  = mem_q[rd_ptr_q];
    assign empty_s = (count_q == CNT_W'(0));
    assign full_s  = (count_q == CNT_W'(QUEUE_DEPTH));
    assign wr_en_s = push_s && (!full_s || pop_s);
    assign drop_s  = push_s && full_s && !pop_s;

    // Sender handshake FSM and queue pop
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        data_d        = data_q;
        pop_s         = 1'b0;
        timeout_inc_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_s && !bus.spi_busy_in) begin
                    state_d = LOAD;
                    pop_s   = 1'b1;
`ifdef SPI_SYNC_PACKET_EN
                    data_d  = head_s[PKT_W] ? {LINES{SYNC_WORD}} : head_s[PKT_W-1:0];
`else
                    data_d  = head_s;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: state_d = TRIG;
            TRIG: begin
                state_d = WAIT_START;
                timer_d = '0;
            end
            WAIT_START: begin
                if (bus.spi_busy_in) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == TMR_W'(START_TIMEOUT - 1)) begin
                    state_d       = IDLE;
                    timeout_inc_s = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!bus.spi_busy_in) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        trigger_d = (state_d == TRIG);
        count_d   = count_q + CNT_W'(wr_en_s) - CNT_W'(pop_s);
        drop_d    = (drop_s && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
        timeout_d = (timeout_inc_s && timeout_q != 8'hFF) ? timeout_q + 8'd1 : timeout_q;
    end

    // State, pointers, counters and registered outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            idx_q     <= '0;
            lanes_q   <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            data_q    <= '0;
            trigger_q <= 1'b0;
            drop_q    <= '0;
            timeout_q <= '0;
`ifdef SPI_SYNC_PACKET_EN
            sync_pend_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            idx_q     <= idx_d;
            lanes_q   <= lanes_d;
            wr_ptr_q  <= wr_ptr_q + PTR_W'(wr_en_s);
            rd_ptr_q  <= rd_ptr_q + PTR_W'(pop_s);
            count_q   <= count_d;
            data_q    <= data_d;
            trigger_q <= trigger_d;
            drop_q    <= drop_d;
            timeout_q <= timeout_d;
`ifdef SPI_SYNC_PACKET_EN
            sync_pend_q <= sync_pend_d;
`endif
        end
    end

    // Queue storage; contents are don't-care while the entry is not counted
    always_ff @(posedge clk_in) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= push_entry_s;
        end
    end

    assign bus.data_out          = data_q;
    assign bus.trigger_out       = trigger_q;
    assign bus.drop_count_out    = drop_q;
    assign bus.timeout_count_out = timeout_q;
endmodule
